// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse character sequencer.
// State encoding, default unit durations and the element limit.
package morse_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TONO,
    S_PAUSA,
    S_FIN
  } estado_t;

  localparam int DEF_PUNTO    = 1;
  localparam int DEF_RAYA     = 3;
  localparam int DEF_GAP_ELEM = 1;
  localparam int DEF_GAP_CAR  = 3;

  localparam int MAX_ELEM = 5;

  // Zero is rejected by the caller; anything above the limit is clamped.
  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    return (l > 3'(MAX_ELEM)) ? 3'(MAX_ELEM) : l;
  endfunction

endpackage

// File: rtl/Mux_8_1_1b.sv
// 8:1 single-bit selector used beside the sequencer.
// Ports: entrada[7:0] data, SEL[2:0] select, salida selected bit.
module Mux_8_1_1b (
  input  logic [7:0] entrada,
  input  logic [2:0] SEL,
  output logic       salida
);

  assign salida = entrada[SEL];

endmodule

// File: rtl/morse_secuenciador.sv
// Plays one latched Morse pattern as a keyed tone paced by tick.
// In: clk, rst_n, iniciar, patron, longitud, tick, bit_mux.
// Out: patron_q, sel, tono, ocupado, listo (all registered).
module morse_secuenciador
  import morse_pkg::*;
#(
  parameter int UNID_PUNTO    = DEF_PUNTO,
  parameter int UNID_RAYA     = DEF_RAYA,
  parameter int UNID_GAP_ELEM = DEF_GAP_ELEM,
  parameter int UNID_GAP_CAR  = DEF_GAP_CAR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iniciar,
  input  logic [4:0] patron,
  input  logic [2:0] longitud,
  input  logic       tick,
  input  logic       bit_mux,
  output logic [4:0] patron_q,
  output logic [2:0] sel,
  output logic       tono,
  output logic       ocupado,
  output logic       listo
);

  localparam logic [1:0] PUNTO_M1 = 2'(UNID_PUNTO - 1);
  localparam logic [1:0] RAYA_M1  = 2'(UNID_RAYA - 1);
  localparam logic [1:0] GAPE_M1  = 2'(UNID_GAP_ELEM - 1);
  localparam logic [1:0] GAPC_M1  = 2'(UNID_GAP_CAR - 1);

  estado_t    state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] len_q, len_d;
  logic [4:0] patron_d;
  logic       tono_q, tono_d;
  logic       ocup_q, ocup_d;
  logic       listo_q, listo_d;
  logic [1:0] dur_m1;

  // sel is held through TONO, so the mux readback is stable.
  assign dur_m1 = bit_mux ? RAYA_M1 : PUNTO_M1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    len_d    = len_q;
    patron_d = patron_q;
    tono_d   = tono_q;
    ocup_d   = ocup_q;
    listo_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (iniciar && (longitud != 3'd0)) begin
          patron_d = patron;
          len_d    = clamp_len(longitud);
          sel_d    = 3'd0;
          cnt_d    = 2'd0;
          tono_d   = 1'b1;
          ocup_d   = 1'b1;
          state_d  = S_TONO;
        end
      end
      S_TONO: begin
        if (tick) begin
          if (cnt_q == dur_m1) begin
            cnt_d  = 2'd0;
            tono_d = 1'b0;
            if (sel_q == len_q - 3'd1)
              state_d = S_FIN;
            else
              state_d = S_PAUSA;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_PAUSA: begin
        if (tick) begin
          if (cnt_q == GAPE_M1) begin
            cnt_d   = 2'd0;
            sel_d   = sel_q + 3'd1;
            tono_d  = 1'b1;
            state_d = S_TONO;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_FIN: begin
        if (tick) begin
          if (cnt_q == GAPC_M1) begin
            cnt_d   = 2'd0;
            listo_d = 1'b1;
            ocup_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      sel_q    <= 3'd0;
      len_q    <= 3'd0;
      patron_q <= 5'd0;
      tono_q   <= 1'b0;
      ocup_q   <= 1'b0;
      listo_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      len_q    <= len_d;
      patron_q <= patron_d;
      tono_q   <= tono_d;
      ocup_q   <= ocup_d;
      listo_q  <= listo_d;
    end
  end

  assign sel     = sel_q;
  assign tono    = tono_q;
  assign ocupado = ocup_q;
  assign listo   = listo_q;

endmodule

// File: tb/tb_morse_secuenciador.sv
// Directed bench for morse_secuenciador with the 8:1 mux beside it.
// Records tono at every tick while busy and checks whole sequences.
module tb_morse_secuenciador;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iniciar = 1'b0;
  logic [4:0] patron = 5'd0;
  logic [2:0] longitud = 3'd0;
  logic       tick = 1'b0;
  logic       bit_mux;
  logic [4:0] patron_q;
  logic [2:0] sel;
  logic       tono;
  logic       ocupado;
  logic       listo;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  every = 1'b0;

  bit  hist[$];
  int  listo_cnt = 0;
  int  ocup_cnt = 0;

  always #5 clk = ~clk;

  morse_secuenciador dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .iniciar  (iniciar),
    .patron   (patron),
    .longitud (longitud),
    .tick     (tick),
    .bit_mux  (bit_mux),
    .patron_q (patron_q),
    .sel      (sel),
    .tono     (tono),
    .ocupado  (ocupado),
    .listo    (listo)
  );

  Mux_8_1_1b u_mux (
    .entrada ({3'b000, patron_q}),
    .SEL     (sel),
    .salida  (bit_mux)
  );

  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      tick = every ? 1'b1 : ((phase % 4) == 0);
    end
  end

  always @(negedge clk) begin
    if (tick && ocupado) hist.push_back(tono);
    if (listo) listo_cnt++;
    if (ocupado) ocup_cnt++;
  end

  task automatic play(input logic [4:0] p, input logic [2:0] l,
                      input bit poke, output int n,
                      output logic [31:0] bits, output int lst,
                      output bit to);
    int base, lbase;
    base  = hist.size();
    lbase = listo_cnt;
    to    = 1'b1;
    @(negedge clk);
    patron = p; longitud = l; iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0; patron = ~p; longitud = 3'd1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (poke && c == 12) begin
        iniciar = 1'b1; patron = 5'b10101; longitud = 3'd3;
      end
      if (poke && c == 13) iniciar = 1'b0;
      if (listo_cnt > lbase) begin
        to = 1'b0;
        break;
      end
    end
    repeat (20) @(negedge clk);
    n = hist.size() - base;
    bits = '0;
    for (int i = base; i < hist.size(); i++)
      bits = {bits[30:0], hist[i]};
    lst = listo_cnt - lbase;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp += 5;
    if (tono !== 1'b0) begin
      n_bad++; $display("FAIL rst_tono got %b want 0", tono);
    end
    if (ocupado !== 1'b0) begin
      n_bad++; $display("FAIL rst_ocupado got %b want 0", ocupado);
    end
    if (listo !== 1'b0) begin
      n_bad++; $display("FAIL rst_listo got %b want 0", listo);
    end
    if (sel !== 3'd0) begin
      n_bad++; $display("FAIL rst_sel got %0d want 0", sel);
    end
    if (patron_q !== 5'd0) begin
      n_bad++; $display("FAIL rst_patron_q got %b want 0", patron_q);
    end
  endtask

  task automatic test_char(input string nm, input logic [4:0] p,
                           input logic [2:0] l, input bit poke,
                           input int en, input logic [31:0] eb,
                           input logic [2:0] es);
    int n, lst;
    logic [31:0] b;
    bit to;
    play(p, l, poke, n, b, lst, to);
    n_cmp += 5;
    if (to) begin
      n_bad++; $display("FAIL %s_timeout no listo seen", nm);
    end
    if (n !== en) begin
      n_bad++; $display("FAIL %s_ticks got %0d want %0d", nm, n, en);
    end
    if (b !== eb) begin
      n_bad++; $display("FAIL %s_tono got %b want %b", nm, b, eb);
    end
    if (lst !== 1) begin
      n_bad++; $display("FAIL %s_listo got %0d want 1", nm, lst);
    end
    if (sel !== es) begin
      n_bad++; $display("FAIL %s_sel got %0d want %0d", nm, sel, es);
    end
    n_cmp++;
    if (ocupado !== 1'b0) begin
      n_bad++; $display("FAIL %s_idle got %b want 0", nm, ocupado);
    end
  endtask

  task automatic test_len_zero();
    int ob, lb;
    ob = ocup_cnt;
    lb = listo_cnt;
    @(negedge clk);
    patron = 5'b11111; longitud = 3'd0; iniciar = 1'b1;
    repeat (3) @(negedge clk);
    iniciar = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp += 2;
    if (ocup_cnt != ob) begin
      n_bad++; $display("FAIL len0_ocupado got %0d want 0", ocup_cnt - ob);
    end
    if (listo_cnt != lb) begin
      n_bad++; $display("FAIL len0_listo got %0d want 0", listo_cnt - lb);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    @(negedge clk);
    patron = 5'b00010; longitud = 3'd2; iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tono && sel == 3'd1) begin
        hit = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_bad++; $display("FAIL rstmid_dash got 0 want 1");
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (tono !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_tono got %b want 0", tono);
    end
    if (ocupado !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_ocupado got %b want 0", ocupado);
    end
    if (sel !== 3'd0) begin
      n_bad++; $display("FAIL rstmid_sel got %0d want 0", sel);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_char("E", 5'b00000, 3'd1, 1'b0, 4, 32'b1000, 3'd0);
    test_char("A", 5'b00010, 3'd2, 1'b0, 8, 32'b10111000, 3'd1);
    test_char("zero", 5'b11111, 3'd5, 1'b0, 22,
              32'b1110111011101110111000, 3'd4);
    test_len_zero();
    test_char("len7", 5'b11111, 3'd7, 1'b0, 22,
              32'b1110111011101110111000, 3'd4);
    test_char("poke", 5'b00010, 3'd2, 1'b1, 8, 32'b10111000, 3'd1);
    test_reset_mid();
    test_char("E_after_rst", 5'b00000, 3'd1, 1'b0, 4, 32'b1000, 3'd0);
    every = 1'b1;
    test_char("A_b2b", 5'b00010, 3'd2, 1'b0, 8, 32'b10111000, 3'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
